// File: rtl/genesis2_readback_pkg.sv
// Shared types and helpers for the genesis2 flop-state readback path.
// Optional parity trailer is enabled by defining READBACK_PARITY_EN.
package genesis2_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int MAX_WIDTH = 1024;

    // Even parity over a word zero-extended to MAX_WIDTH.
    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rb_shifter.sv
// Capture/shift register and bit counter for one readback frame.
// With READBACK_PARITY_EN defined it also latches the captured word's parity.
module rb_shifter
    import genesis2_readback_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             bit0,
`ifdef READBACK_PARITY_EN
    output logic             par,
`endif
    output logic             last
);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    assign bit0 = shreg[0];
    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Counter holds at WIDTH-1 on the final shift so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= d;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg >> 1;
            if (!last) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef READBACK_PARITY_EN
    logic [MAX_WIDTH-1:0] d_ext;
    logic                 par_q;

    always_comb begin
        d_ext            = '0;
        d_ext[WIDTH-1:0] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= even_parity(d_ext);
        end
    end

    assign par = par_q;
`endif

endmodule

// File: rtl/ff_readback.sv
// Snapshot-and-shift readback of fabric flop state, streamed LSB-first.
// Define READBACK_PARITY_EN to append an even-parity bit to each frame.
//
// Serial link: a bit transfers on a rising edge where so_valid and so_ready
// are both high; so/so_valid stay stable while so_ready is low, and so_valid
// never depends combinationally on so_ready.
module ff_readback
    import genesis2_readback_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             c,
    input  logic             rn,
    input  logic             start,
    input  logic [WIDTH-1:0] q_par,
    output logic             so,
    output logic             so_valid,
    input  logic             so_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("ff_readback: WIDTH out of range");
    end

    state_t state;
    logic   hs;
    logic   load;
    logic   shift;
    logic   bit0;
    logic   last;
`ifdef READBACK_PARITY_EN
    logic   par;
`endif

    assign hs        = so_valid & so_ready;
    assign load      = (state == ST_IDLE) & start;
    assign shift     = (state == ST_SHIFT) & hs;
    assign dbg_state = state;

    rb_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (c),
        .rst_n (rn),
        .load  (load),
        .shift (shift),
        .d     (q_par),
        .bit0  (bit0),
`ifdef READBACK_PARITY_EN
        .par   (par),
`endif
        .last  (last)
    );

    // Serial data is decoded from state and stored bits only.
    always_comb begin
        so = 1'b0;
        case (state)
            ST_SHIFT:  so = bit0;
`ifdef READBACK_PARITY_EN
            ST_PARITY: so = par;
`endif
            default:   so = 1'b0;
        endcase
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state    <= ST_IDLE;
            so_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SHIFT;
                        so_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (hs && last) begin
`ifdef READBACK_PARITY_EN
                        state    <= ST_PARITY;
`else
                        state    <= ST_DONE;
                        so_valid <= 1'b0;
                        done     <= 1'b1;
`endif
                    end
                end
`ifdef READBACK_PARITY_EN
                ST_PARITY: begin
                    if (hs) begin
                        state    <= ST_DONE;
                        so_valid <= 1'b0;
                        done     <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    so_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_readback.sv
// Directed plus randomized bench for ff_readback (WIDTH=8 and WIDTH=1 instances).
module tb_ff_readback;
    import genesis2_readback_pkg::*;

`ifdef READBACK_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    localparam int W8 = 8;
    localparam int L8 = W8 + PAR_EN;
    localparam int L1 = 1 + PAR_EN;

    // clock / reset
    logic clk = 1'b0;
    logic rn  = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] q8     = 8'h00;
    logic       rdy8   = 1'b0;
    logic       so8, sov8, busy8, done8;
    logic [1:0] st8;

    logic       start1 = 1'b0;
    logic       q1     = 1'b0;
    logic       rdy1   = 1'b0;
    logic       so1, sov1, busy1, done1;
    logic [1:0] st1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [0:0] exp_q[$];

    ff_readback #(.WIDTH(W8)) u8 (
        .c(clk), .rn(rn), .start(start8), .q_par(q8), .so(so8), .so_valid(sov8),
        .so_ready(rdy8), .busy(busy8), .done(done8), .dbg_state(st8)
    );

    ff_readback #(.WIDTH(1)) u1 (
        .c(clk), .rn(rn), .start(start1), .q_par(q1), .so(so1), .so_valid(sov1),
        .so_ready(rdy1), .busy(busy1), .done(done1), .dbg_state(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one frame on the WIDTH=8 instance, scoreboarded bit by bit
    task automatic run_frame8(input logic [7:0] word, input int stall_pct,
                              input logic [31:0] stall_mask, input int restart_at,
                              input int change_at, input int exp_done_cycle);
        int cycle;
        int done_cycle;
        exp_q.delete();
        for (int i = 0; i < W8; i++) exp_q.push_back(word[i]);
        if (PAR_EN != 0) exp_q.push_back(^word);
        @(posedge clk); #1;
        start8 = 1'b1;
        q8     = word;
        @(posedge clk); #1;
        start8     = 1'b0;
        cycle      = 1;
        done_cycle = -1;
        while (cycle < 200 && done_cycle < 0) begin
            start8 = (cycle == restart_at);
            if (cycle == change_at) q8 = 8'hFF;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check("shift_busy", busy8, 1);
                check("shift_valid", sov8, 1);
                check("shift_done_low", done8, 0);
                check("so_bit", so8, exp_q[0]);
                rdy8 = !(cycle < 32 && stall_mask[cycle]) && ($urandom_range(99) >= stall_pct);
                if (rdy8) void'(exp_q.pop_front());
            end else begin
                rdy8 = 1'($urandom_range(1));
                check("done_pulse", done8, 1);
                check("done_valid_low", sov8, 0);
                check("done_busy", busy8, 1);
                done_cycle = cycle;
            end
            @(posedge clk); #1;
            cycle++;
        end
        start8 = 1'b0;
        check("frame_timeout", (done_cycle >= 0), 1);
        if (exp_done_cycle > 0) check("done_cycle", done_cycle, exp_done_cycle);
        @(negedge clk);
        check("post_busy", busy8, 0);
        check("post_done", done8, 0);
        check("post_valid", sov8, 0);
        @(negedge clk);
        check("no_second_frame", busy8, 0);
        check("single_done", done8, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] word;
        int pos;
        logic exp_so;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_so", so8, 0);
        check("rst_valid", sov8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_state", st8, ST_IDLE);
        check("rst_valid_w1", sov1, 0);
        rn = 1'b1;
        @(negedge clk);

        // 0xA5, zero backpressure
        run_frame8(8'hA5, 0, 32'h0, -1, -1, L8 + 1);
        // stall on cycles 3..5 while bit 2 is presented
        run_frame8(8'hA5, 0, 32'h38, -1, -1, L8 + 4);
        // restart ignored mid-frame, Q_PAR change after capture ignored
        run_frame8(8'hA5, 0, 32'h0, 4, 2, L8 + 1);

        // reset mid-frame
        @(posedge clk); #1;
        start8 = 1'b1;
        q8     = 8'h3C;
        rdy8   = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rn = 1'b0;
        #1;
        check("rst_mid_valid", sov8, 0);
        check("rst_mid_busy", busy8, 0);
        check("rst_mid_so", so8, 0);
        check("rst_mid_done", done8, 0);
        check("rst_mid_state", st8, ST_IDLE);
        @(negedge clk);
        rn = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", done8, 0);
            check("rst_idle", busy8, 0);
        end
        run_frame8(8'h5A, 0, 32'h0, -1, -1, L8 + 1);

        // WIDTH=1 frames for both bit values
        for (int v = 1; v >= 0; v--) begin
            @(posedge clk); #1;
            start1 = 1'b1;
            q1     = 1'(v);
            rdy1   = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            for (int cyc = 1; cyc <= L1 + 2; cyc++) begin
                @(negedge clk);
                check("w1_valid", sov1, (cyc <= L1) ? 1 : 0);
                check("w1_so", so1, (cyc <= L1) ? v : 0);
                check("w1_done", done1, (cyc == L1 + 1) ? 1 : 0);
                check("w1_busy", busy1, (cyc <= L1 + 1) ? 1 : 0);
                @(posedge clk); #1;
            end
        end

        // back-to-back: START held high for two frames
        word = 8'($urandom);
        @(posedge clk); #1;
        start8 = 1'b1;
        q8     = word;
        rdy8   = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 2 * (L8 + 2); cyc++) begin
            @(negedge clk);
            pos = (cyc - 1) % (L8 + 2);
            if (pos < W8) exp_so = word[pos];
            else if (pos == W8 && PAR_EN != 0) exp_so = ^word;
            else exp_so = 1'b0;
            check("b2b_valid", sov8, (pos < L8) ? 1 : 0);
            check("b2b_so", so8, exp_so);
            check("b2b_done", done8, (pos == L8) ? 1 : 0);
            check("b2b_busy", busy8, (pos != L8 + 1) ? 1 : 0);
            if (cyc == 2 * (L8 + 2)) start8 = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b2b_stop", busy8, 0);

        // randomized words with random backpressure
        repeat (12) begin
            run_frame8(8'($urandom), 35, 32'h0, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
